// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, stage payload layouts,
// per-stage bubble payloads and the skid buffer state encoding.
package pipe_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int OP_W   = 32;
  localparam int RD_W   = 5;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
  } if_id_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
    logic [OP_W-1:0]   op1;
    logic [OP_W-1:0]   op2;
    logic [RD_W-1:0]   rd;
    logic              wen;
  } id_ex_t;

  localparam int IF_ID_W = $bits(if_id_t);
  localparam int ID_EX_W = $bits(id_ex_t);

  localparam if_id_t IF_ID_BUBBLE = '{
    inst: INST_NOP,
    addr: '0
  };

  localparam id_ex_t ID_EX_BUBBLE = '{
    inst: INST_NOP,
    addr: '0,
    op1:  '0,
    op2:  '0,
    rd:   '0,
    wen:  1'b0
  };

  // Encoding mirrors {skid_v, main_v}
  typedef enum logic [1:0] {
    SB_EMPTY = 2'b00,
    SB_ONE   = 2'b01,
    SB_FULL  = 2'b11
  } skid_st_e;

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready payload channel between pipeline stages.
// Master drives valid/data, slave drives ready.
interface pipe_stage_hs_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: main entry feeds the output, skid entry
// catches the one payload accepted while downstream was stalled.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_xfer_i,
  input  logic              out_xfer_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              main_v_o,
  output logic              skid_v_o,
  output logic [DATA_W-1:0] main_o
);

  skid_st_e          st_q, st_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= SB_EMPTY;
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
    end else begin
      st_q   <= st_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush_i) begin
      st_d   = SB_EMPTY;
      main_d = BUBBLE;
      skid_d = BUBBLE;
    end else begin
      unique case (st_q)
        SB_EMPTY: begin
          if (in_xfer_i) begin
            st_d   = SB_ONE;
            main_d = in_data_i;
          end
        end
        SB_ONE: begin
          if (in_xfer_i && out_xfer_i) begin
            main_d = in_data_i;
          end else if (in_xfer_i) begin
            st_d   = SB_FULL;
            skid_d = in_data_i;
          end else if (out_xfer_i) begin
            st_d   = SB_EMPTY;
            main_d = BUBBLE;
          end
        end
        SB_FULL: begin
          // Full never accepts, so only the drain path exists
          if (out_xfer_i) begin
            st_d   = SB_ONE;
            main_d = skid_q;
            skid_d = BUBBLE;
          end
        end
        default: begin
          st_d   = SB_EMPTY;
          main_d = BUBBLE;
          skid_d = BUBBLE;
        end
      endcase
    end
  end

  assign main_v_o = (st_q != SB_EMPTY);
  assign skid_v_o = (st_q == SB_FULL);
  assign main_o   = main_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, flush, hold,
// optional skid buffer and a saturating downstream-stall counter.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter bit                SKID   = 1'b1,
  parameter int                CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             hold_i,
  pipe_stage_hs_if.slave   up_if,
  pipe_stage_hs_if.master  dn_if,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              alive_q;
  logic              main_v;
  logic [DATA_W-1:0] main_data;
  logic              room;
  logic              in_xfer;
  logic              out_xfer;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Keeps in_ready low for one cycle after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alive_q <= 1'b0;
    else     alive_q <= 1'b1;
  end

  assign dn_if.valid = main_v & ~hold_i;
  assign dn_if.data  = dn_if.valid ? main_data : BUBBLE;
  assign up_if.ready = alive_q & room & ~flush_i & ~hold_i;

  assign in_xfer  = up_if.valid & up_if.ready;
  assign out_xfer = dn_if.valid & dn_if.ready & ~flush_i;

  if (SKID) begin : g_skid
    logic skid_v;

    pipe_skid_buf #(
      .DATA_W (DATA_W),
      .BUBBLE (BUBBLE)
    ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush_i),
      .in_xfer_i  (in_xfer),
      .out_xfer_i (out_xfer),
      .in_data_i  (up_if.data),
      .main_v_o   (main_v),
      .skid_v_o   (skid_v),
      .main_o     (main_data)
    );

    assign room = ~skid_v;
  end else begin : g_reg
    logic              v_q, v_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q    <= 1'b0;
        data_q <= BUBBLE;
      end else begin
        v_q    <= v_d;
        data_q <= data_d;
      end
    end

    always_comb begin
      v_d    = v_q;
      data_d = data_q;
      if (flush_i) begin
        v_d    = 1'b0;
        data_d = BUBBLE;
      end else if (in_xfer) begin
        v_d    = 1'b1;
        data_d = up_if.data;
      end else if (out_xfer) begin
        v_d    = 1'b0;
        data_d = BUBBLE;
      end
    end

    assign main_v    = v_q;
    assign main_data = data_q;
    assign room      = ~v_q | dn_if.ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (dn_if.valid && !dn_if.ready && !flush_i && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign stall_cnt = cnt_q;

endmodule
